// File: rtl/apb_initiator.sv
// ---------------------------------------------------------------------------
// apb_initiator
//
// APB4 requester bridge. It takes one transfer at a time from a valid/ready
// request port and runs the APB SETUP/ACCESS sequence on the bus. Read data
// and error status come back on a valid/ready response port. If the slave
// holds pready low for too long, a timeout aborts the transfer so that the
// initiator cannot hang.
//
// Every output is driven straight from a register. The next value of each
// register is computed in a single combinational block, and a single clocked
// block updates all of them.
//
// Parameters:
//   ADDR_WIDTH  width of req_addr / paddr
//   DATA_WIDTH  width of the data buses (a multiple of 8)
//   TIMEOUT     the most ACCESS cycles spent waiting for pready before an
//               abort; 0 turns the timeout off
//
// Ports:
//   pclk, presetn        clock; asynchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready is high only in IDLE)
//   req_addr/req_write/req_wdata/req_strb   request payload, latched on
//                        acceptance
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes and for timeouts)
//   rsp_err              pslverr or timeout
//   rsp_timeout          transfer aborted by the timeout
//   psel/penable/pwrite/paddr/pwdata/pstrb  APB requester outputs
//   pready/prdata/pslverr                   APB completer inputs
// ---------------------------------------------------------------------------
module apb_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    presetn,
  // request port
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_write,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB bus
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // A counter of at least one bit keeps the logic legal when TIMEOUT = 0.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic             TO_EN     = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // APB4 requires the write data and strobes of a read to be zero. These
  // helpers apply that rule when the request is latched.
  function automatic logic [DATA_WIDTH-1:0] bus_wdata(input logic                  wr,
                                                      input logic [DATA_WIDTH-1:0] d);
    bus_wdata = wr ? d : {DATA_WIDTH{1'b0}};
  endfunction

  function automatic logic [STRB_W-1:0] bus_strb(input logic              wr,
                                                 input logic [STRB_W-1:0] s);
    bus_strb = wr ? s : {STRB_W{1'b0}};
  endfunction

  // state and output registers
  state_t                  state_r,       state_s;
  logic [CNT_W-1:0]        cnt_r,         cnt_s;
  logic                    req_ready_r,   req_ready_s;
  logic                    rsp_valid_r,   rsp_valid_s;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r,   rsp_rdata_s;
  logic                    rsp_err_r,     rsp_err_s;
  logic                    rsp_timeout_r, rsp_timeout_s;
  logic                    psel_r,        psel_s;
  logic                    penable_r,     penable_s;
  logic                    pwrite_r,      pwrite_s;
  logic [ADDR_WIDTH-1:0]   paddr_r,       paddr_s;
  logic [DATA_WIDTH-1:0]   pwdata_r,      pwdata_s;
  logic [STRB_W-1:0]       pstrb_r,       pstrb_s;
  logic                    timeout_hit_s;

  // This is the wait-cycle limit. When pready arrives on the limit cycle, it
  // takes priority because it is tested first in the ACCESS branch below.
  assign timeout_hit_s = TO_EN && (cnt_r == TIMEOUT_C);

  // Next-state and next-output logic. Every register holds its value unless a
  // branch below changes it.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_err_s     = rsp_err_r;
    rsp_timeout_s = rsp_timeout_r;
    psel_s        = psel_r;
    penable_s     = penable_r;
    pwrite_s      = pwrite_r;
    paddr_s       = paddr_r;
    pwdata_s      = pwdata_r;
    pstrb_s       = pstrb_r;

    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          // The bus registers hold the latched request for the whole transfer.
          state_s   = ST_SETUP;
          cnt_s     = {CNT_W{1'b0}};
          psel_s    = 1'b1;
          penable_s = 1'b0;
          pwrite_s  = req_write;
          paddr_s   = req_addr;
          pwdata_s  = bus_wdata(req_write, req_wdata);
          pstrb_s   = bus_strb(req_write, req_strb);
        end else begin
          state_s   = ST_IDLE;
          psel_s    = 1'b0;
          penable_s = 1'b0;
        end
      end

      ST_SETUP: begin
        state_s   = ST_ACCESS;
        psel_s    = 1'b1;
        penable_s = 1'b1;
      end

      ST_ACCESS: begin
        if (pready) begin
          state_s       = ST_RESP;
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_rdata_s   = pwrite_r ? {DATA_WIDTH{1'b0}} : prdata;
          rsp_err_s     = pslverr;
          rsp_timeout_s = 1'b0;
        end else if (timeout_hit_s) begin
          state_s       = ST_RESP;
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_valid_s   = 1'b1;
          rsp_rdata_s   = {DATA_WIDTH{1'b0}};
          rsp_err_s     = 1'b1;
          rsp_timeout_s = 1'b1;
        end else begin
          // This counter only matters when the timeout is enabled. With the
          // timeout off, letting it wrap is harmless.
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
        end else begin
          state_s     = ST_RESP;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase

    // req_ready is registered. It tracks the state the FSM is about to enter,
    // so it is high exactly while the FSM sits in IDLE.
    req_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers. The asynchronous reset clears all of them, so
  // psel/penable drop at once and any in-flight transfer or pending response
  // is lost.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      req_ready_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_WIDTH{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= {ADDR_WIDTH{1'b0}};
      pwdata_r      <= {DATA_WIDTH{1'b0}};
      pstrb_r       <= {STRB_W{1'b0}};
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      req_ready_r   <= req_ready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_err_r     <= rsp_err_s;
      rsp_timeout_r <= rsp_timeout_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      pwrite_r      <= pwrite_s;
      paddr_r       <= paddr_s;
      pwdata_r      <= pwdata_s;
      pstrb_r       <= pstrb_s;
    end
  end

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;
  assign psel        = psel_r;
  assign penable     = penable_r;
  assign pwrite      = pwrite_r;
  assign paddr       = paddr_r;
  assign pwdata      = pwdata_r;
  assign pstrb       = pstrb_r;

endmodule

// File: tb/tb_apb_initiator.sv
// ---------------------------------------------------------------------------
// tb_apb_initiator
//
// Directed bench for apb_initiator, built with TIMEOUT = 4.
// - A small behavioural APB slave inserts a programmable number of wait
//   states. It can also hold pready low forever.
// - Each test pushes the response it expects into a scoreboard queue.
// - A monitor pops that queue on every response handshake and compares.
// - Bus timing and handshake checks are made inline in the stimulus.
// ---------------------------------------------------------------------------
module tb_apb_initiator;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  int   vec_cnt = 0;
  int   miscmp  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // Slave controls and the slave's record of ACCESS cycles in the last transfer
  int          sl_wait  = 0;
  bit          sl_stuck = 1'b0;
  bit          sl_err   = 1'b0;
  logic [31:0] sl_rdata = 32'h0;
  int          acc_cnt  = 0;

  apb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural slave. It is updated on the falling edge, so pready is stable
  // at the rising edge where the initiator samples it.
  always @(negedge pclk) begin
    if (psel && !penable) begin
      acc_cnt = 0;
      pready  = 1'b0;
    end else if (psel && penable) begin
      pready  = !sl_stuck && (acc_cnt >= sl_wait);
      acc_cnt = acc_cnt + 1;
    end else begin
      pready  = 1'b0;
    end
    pslverr = pready && sl_err;
    prdata  = pready ? sl_rdata : 32'hBAD0_BAD0;
  end

  // Response monitor. A handshake is seen on the falling edge before the
  // rising edge that completes it.
  always @(negedge pclk) begin
    if (presetn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata",   rsp_rdata,          mon_e.rdata);
        check("rsp_err",     {31'd0, rsp_err},     {31'd0, mon_e.err});
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, mon_e.to});
      end
    end
  end

  // Issue one request and wait for it to be accepted. On return the time is
  // just after acceptance edge N, so the DUT is in SETUP.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s);
    bit ok = 1'b0;
    req_addr = a; req_write = w; req_wdata = d; req_strb = s; req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge pclk);
      if (req_ready) ok = 1'b1;
    end
    @(posedge pclk);
    #1;
    // Scramble the request inputs: the bus values must come from the latch.
    req_valid = 1'b0; req_addr = ~a; req_wdata = ~d; req_strb = ~s; req_write = ~w;
    if (!ok) check("req_accept_wait", 32'd0, 32'd1);
  endtask

  // Wait until every expected response has been consumed, up to a cycle
  // budget.
  task automatic wait_done();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge pclk);
      if (sb_q.size() == 0) done = 1'b1;
    end
    @(posedge pclk);
    #1;
    if (!done) begin
      check("rsp_wait", 32'd0, 32'd1);
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    presetn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0;
    req_wdata = 32'h0; req_strb = 4'h0; rsp_ready = 1'b1;

    // Reset values
    #2;
    check("rst_psel",      {31'd0, psel},      32'd0);
    check("rst_penable",   {31'd0, penable},   32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_paddr",     paddr,              32'd0);
    check("rst_rsp_rdata", rsp_rdata,          32'd0);
    #10 presetn = 1'b1;
    @(posedge pclk); #1;
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: zero-wait write. prdata is nonzero, but the write must return 0.
    sl_wait = 0; sl_rdata = 32'hCAFE_F00D;
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    issue(32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF);
    check("t1_setup_psel",    {31'd0, psel},      32'd1);
    check("t1_setup_penable", {31'd0, penable},   32'd0);
    check("t1_setup_paddr",   paddr,              32'h4);
    check("t1_setup_pwdata",  pwdata,             32'hDEAD_BEEF);
    check("t1_setup_pstrb",   {28'd0, pstrb},     32'hF);
    check("t1_setup_pwrite",  {31'd0, pwrite},    32'd1);
    check("t1_busy_req_ready",{31'd0, req_ready}, 32'd0);
    @(posedge pclk); #1;
    check("t1_acc_psel",    {31'd0, psel},    32'd1);
    check("t1_acc_penable", {31'd0, penable}, 32'd1);
    check("t1_acc_paddr",   paddr,            32'h4);
    check("t1_acc_pwdata",  pwdata,           32'hDEAD_BEEF);
    @(posedge pclk); #1;
    check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_rsp_psel",  {31'd0, psel},      32'd0);
    wait_done();

    // 2: read with 3 wait states. pwdata and pstrb must be zero for a read.
    sl_wait = 3; sl_rdata = 32'h1234_5678;
    sb_q.push_back('{32'h1234_5678, 1'b0, 1'b0});
    issue(32'h8, 1'b0, 32'hFFFF_FFFF, 4'hF);
    check("t2_pstrb",  {28'd0, pstrb},  32'h0);
    check("t2_pwdata", pwdata,          32'h0);
    check("t2_pwrite", {31'd0, pwrite}, 32'd0);
    wait_done();
    check("t2_access_len", acc_cnt, 32'd4);

    // 3: slave error on a read
    sl_wait = 1; sl_err = 1'b1; sl_rdata = 32'hA5A5_0F0F;
    sb_q.push_back('{32'hA5A5_0F0F, 1'b1, 1'b0});
    issue(32'hC, 1'b0, 32'h0, 4'h0);
    wait_done();
    sl_err = 1'b0;

    // 4a: pready stuck low, so the transfer aborts on the 5th ACCESS cycle
    sl_stuck = 1'b1;
    sb_q.push_back('{32'h0, 1'b1, 1'b1});
    issue(32'h10, 1'b0, 32'h0, 4'h0);
    wait_done();
    check("t4a_access_len", acc_cnt, 32'd5);
    sl_stuck = 1'b0;

    // 4b: pready arrives on the limit cycle and wins over the timeout
    sl_wait = 4; sl_rdata = 32'h7777_0004;
    sb_q.push_back('{32'h7777_0004, 1'b0, 1'b0});
    issue(32'h14, 1'b0, 32'h0, 4'h0);
    wait_done();
    check("t4b_access_len", acc_cnt, 32'd5);

    // 5: response backpressure with a second request already queued
    sl_wait = 0; sl_rdata = 32'h1111_2222; rsp_ready = 1'b0;
    sb_q.push_back('{32'h1111_2222, 1'b0, 1'b0});
    sb_q.push_back('{32'h0, 1'b0, 1'b0});
    issue(32'h20, 1'b0, 32'h0, 4'h0);
    req_addr = 32'h24; req_write = 1'b1; req_wdata = 32'h55AA_55AA; req_strb = 4'h3;
    req_valid = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid",     {31'd0, rsp_valid}, 32'd1);
      check("t5_hold_rdata",     rsp_rdata,          32'h1111_2222);
      check("t5_hold_req_ready", {31'd0, req_ready}, 32'd0);
      check("t5_hold_psel",      {31'd0, psel},      32'd0);
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    check("t5_gap_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_gap_psel",      {31'd0, psel},      32'd0);
    check("t5_gap_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge pclk); #1;
    req_valid = 1'b0;
    check("t5_second_psel",  {31'd0, psel},  32'd1);
    check("t5_second_paddr", paddr,          32'h24);
    check("t5_second_pstrb", {28'd0, pstrb}, 32'h3);
    wait_done();

    // 6: reset in ACCESS drops psel/penable without waiting for a clock edge
    sl_stuck = 1'b1;
    issue(32'h30, 1'b0, 32'h0, 4'h0);
    @(posedge pclk); #1;
    check("t6_in_access", {31'd0, penable}, 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("t6_rst_psel",      {31'd0, psel},      32'd0);
    check("t6_rst_penable",   {31'd0, penable},   32'd0);
    check("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #10 presetn = 1'b1;
    sl_stuck = 1'b0; sl_wait = 2; sl_rdata = 32'h9999_8888;
    @(posedge pclk); #1;
    check("t6_post_req_ready", {31'd0, req_ready}, 32'd1);
    sb_q.push_back('{32'h9999_8888, 1'b0, 1'b0});
    issue(32'h34, 1'b0, 32'h0, 4'h0);
    wait_done();
    check("t6_access_len", acc_cnt, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- APB4 requester (master) bridge that drives the slave-side bus of the generated register blocks (psel/penable/pwrite/paddr/pwdata/pstrb in; pready/prdata/pslverr out).
- Accepts one transfer at a time from a simple valid/ready request port and runs the APB SETUP/ACCESS sequence.
- Returns read data and error status on a valid/ready response port.
- Adds a pready timeout, so an unresponsive slave cannot hang the initiator.

Parameters:
ADDR_WIDTH, 32, width of req_addr/paddr
DATA_WIDTH, 32, width of data buses; multiple of 8
TIMEOUT, 255, max ACCESS cycles waiting for pready before abort; 0 = no timeout

Ports:
pclk  in  1  clock
presetn  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_addr  in  ADDR_WIDTH  byte address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  pslverr or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pready  in  1  slave ready
prdata  in  DATA_WIDTH  slave read data
pslverr  in  1  slave error

Behaviour:
- Clock and reset: one clock, pclk. presetn is asynchronous and active-low.
- Reset values: every output is 0, state IDLE, timeout counter 0.
- Reset mid-transfer: psel/penable drop immediately (asynchronously); the in-flight transfer and any pending response are discarded.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - req_ready=1 only in IDLE.
  - On req_valid&req_ready, latch addr/write/wdata/strb and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0.
  - paddr/pwrite/pwdata/pstrb driven from the latched values.
  - Go to ACCESS.
- ACCESS:
  - psel=1, penable=1. paddr/pwrite/pwdata/pstrb held stable.
  - pready=1: capture prdata (reads only; writes capture 0) and pslverr into rsp_rdata/rsp_err. rsp_timeout=0, rsp_valid=1, psel=penable=0, go to RESP.
  - pready=0: increment counter.
- Timeout (TIMEOUT>0):
  - When the counter equals TIMEOUT and pready=0, abort: psel=penable=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, go to RESP.
  - pready=1 on the same cycle as the counter limit: pready wins and the transfer completes normally.
  - Counter clears on entry to SETUP. Counter width is clog2(TIMEOUT+1).
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid=0 and go to IDLE.
  - rsp_ready is ignored when rsp_valid=0.
- Read/idle bus values:
  - Reads drive pstrb=0 and pwdata=0 (APB4 rule).
  - In IDLE/RESP, paddr/pwdata/pstrb/pwrite keep their last values; only psel/penable are guaranteed 0.
- Latency and throughput:
  - Request accepted at edge N.
  - psel rises after edge N (SETUP), penable rises after edge N+1.
  - With pready=1 on the first ACCESS cycle, rsp_valid rises after edge N+2.
  - Minimum 4 cycles per transfer with rsp_ready held high. No overlap between transfers.
- Behaviour outside IDLE: req_valid has no effect and request inputs may change freely.

Test Plan:
1. Zero-wait write: req addr=0x4, wdata=0xDEADBEEF, strb=0xF, pready tied 1 -> psel 1 cycle with penable=0, then 1 cycle with penable=1; paddr=0x4, pwdata=0xDEADBEEF; rsp_valid after 3 cycles with rdata=0, err=0.
2. Read with 3 wait states: slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x12345678 -> ACCESS lasts 4 cycles, pstrb=0, rsp_rdata=0x12345678, err=0, timeout=0.
3. Slave error: read with pslverr=1 on the pready cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
4. Timeout with TIMEOUT=4 and pready stuck 0 -> psel drops after 5 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 on the limit cycle -> normal completion, timeout=0.
5. Response backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0 throughout; a queued req_valid is accepted only after the response is consumed, with psel=0 for at least 1 cycle between transfers.
6. Reset in ACCESS: assert presetn=0 mid-ACCESS -> psel/penable/rsp_valid go 0 without waiting for a clock edge. After release, req_ready=1 and a new read completes normally.
